core_rrv_pipe_hazard_ctrl: RTL and testbench
============================================

Name: core_rrv_pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control engine for the rrv core family. It replaces the hard-wired 5-stage ready/valid/flush/load-hazard logic with a generic N-stage valid pipeline.
- It adds a register scoreboard with configurable load-data stage, a configurable fetch-shadow flush, and a multi-cycle execute FSM (for a future M-extension divider).
- It sits beside the decoder. It consumes decoded fields for the stage-1 (Q101H) instruction and produces per-stage Ready/Valid vectors for the datapath.

Parameters:
- NUM_STAGES, 5, number of pipe stages after fetch. Stage k is Q10kH, k=1..NUM_STAGES. Minimum 4.
- LOAD_DATA_STAGE, 4, first stage whose load result is forwardable. Must satisfy 3 <= LOAD_DATA_STAGE <= NUM_STAGES.
- FETCH_LAT, 2, number of cycles of wrong-path fetch killed by a flush, including the flush cycle. Range 1..4.
- MC_LAT, 4, total cycles a multi-cycle op occupies stage 2. Range 1..64.
- REG_ADDR_W, 5, register index width.

Ports:
- Clock  in  1  core clock.
- Rst  in  1  asynchronous reset, active-high.
- DMemReady  in  1  data-memory ready. Low freezes the whole core.
- DecValidQ101H  in  1  stage-1 slot holds a fetched instruction.
- DecRs1Q101H  in  REG_ADDR_W  source 1 index.
- DecRs2Q101H  in  REG_ADDR_W  source 2 index.
- DecRs1UsedQ101H  in  1  rs1 is actually read by the instruction.
- DecRs2UsedQ101H  in  1  rs2 is actually read by the instruction.
- DecRdQ101H  in  REG_ADDR_W  destination register.
- DecRegWrEnQ101H  in  1  instruction writes rd.
- DecIsLoadQ101H  in  1  instruction is a load.
- DecIsMcQ101H  in  1  instruction is a multi-cycle execute op.
- FlushQ102H  in  1  taken branch/jump resolved in stage 2.
- Ready  out  NUM_STAGES+1  Ready[k] enables the sample into stage k+1. Ready[0] is the PC/fetch enable.
- Valid  out  NUM_STAGES  Valid[k-1] is the valid bit of stage k.
- KillQ101H  out  1  stage-1 instruction is squashed. The decoder substitutes a NOP.
- LoadHazardQ101H  out  1  load-use stall active.
- McBusy  out  1  multi-cycle FSM in BUSY.
- RetireValid  out  1  the last stage retires this cycle.
- RegWrEnWb  out  1  RetireValid and the last stage's RegWrEn.

Behaviour:
- Reset (asynchronous):
  - All stage valid bits, rd, RegWrEn and IsLoad fields clear.
  - FSM goes to IDLE; McCnt=0; KillCnt=0.
  - Valid=0, McBusy=0, RetireValid=0, RegWrEnWb=0 while Rst is high.
- Per stage k>=2, registers hold: valid, rd, RegWrEn, IsLoad, IsMc. Each stage loads from stage k-1 when Ready[k-1]=1.
- A stage k that holds while stage k-1 advances cannot occur. When stage k holds but stage k+1 advances, stage k+1 receives a bubble (valid=0).
- Freeze = !DMemReady:
  - All Ready=0; every register, McCnt and KillCnt hold.
  - Freeze has highest priority.
- Kill:
  - KillQ101H = FlushQ102H | (KillCnt!=0).
  - On a non-frozen cycle with FlushQ102H=1, KillCnt loads FETCH_LAT-1. Otherwise it decrements if nonzero.
  - A killed stage-1 instruction enters stage 2 with valid=0.
- Load hazard:
  - Asserted when stage 1 is valid and not killed, and a used source rs != 0 equals rd of a valid load in any stage 2..LOAD_DATA_STAGE-1.
  - x0 and unused sources never stall.
  - Effect: Ready[0]=Ready[1]=0, and stage 2 receives a bubble.
- Multi-cycle FSM (IDLE/BUSY):
  - IDLE to BUSY when stage 2 is valid with IsMc, MC_LAT>1, and not frozen. McCnt loads MC_LAT-2.
  - In BUSY: Ready[0..2]=0, stage 3 gets bubbles, McCnt decrements each non-frozen cycle.
  - When McCnt==0 in BUSY: go to IDLE, and Ready[2]=1 that cycle, so the op advances.
  - The op therefore spends exactly MC_LAT non-frozen cycles in stage 2. MC_LAT=1 never stalls.
- Ready[2]=0 also forces Ready[1]=Ready[0]=0. A valid op held in stage 2 during IDLE entry also holds stages 0..1.
- Priority: freeze > McBusy/MC-entry hold > flush > load hazard.
  - A flush overrides a load hazard: Ready[0]=Ready[1]=1 and the stage-1 slot is killed.
  - FlushQ102H while stage 2 holds an MC op is illegal (SVA).
- Ready[k] for k>=3 = !Freeze.
- RetireValid = Valid[NUM_STAGES-1] & Ready[NUM_STAGES].
- Simultaneous flush and KillCnt!=0: KillCnt reloads.
- Rst asserted mid-BUSY or mid-kill: state is cleared immediately.

Test Plan:
- Back-to-back ops, default parameters: lw x5 followed by add x6,x5,x5 -> LoadHazardQ101H high exactly 2 cycles. Stage 2 sees 2 bubbles, then add issues; Ready[1]=0 for both cycles.
- lw x0 then add x1,x0,x0, plus lw x5 then lui x5 (no rs used) -> no stall in either case, Ready[1] stays 1.
- FlushQ102H pulse with FETCH_LAT=2 -> KillQ101H high 2 cycles, 2 consecutive stage-2 bubbles. With a load hazard pending in the same cycle, the flush wins and Ready[1]=1.
- MC op with MC_LAT=4 -> op stays in stage 2 for 4 cycles, McBusy high 3 cycles, 3 bubbles into stage 3. Ready[0] is low for the stall cycles.
- DMemReady low 3 cycles mid-BUSY -> McCnt frozen, stall extended by exactly 3 cycles, no valid bit lost or duplicated. RetireValid count equals issued count.
- Rst asserted during BUSY with KillCnt=1 -> all Valid=0, McBusy=0, KillQ101H=0 asynchronously. First post-reset instruction retires after NUM_STAGES-1 cycles.

Source files
------------

// File: rtl/core_rrv_pipe_hazard_ctrl.sv
// core_rrv_pipe_hazard_ctrl: N-stage valid pipeline control with load-use scoreboard, fetch-shadow flush and multi-cycle execute FSM
module core_rrv_pipe_hazard_ctrl #(
  parameter int NUM_STAGES      = 5,
  parameter int LOAD_DATA_STAGE = 4,
  parameter int FETCH_LAT       = 2,
  parameter int MC_LAT          = 4,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  DMemReady,
  input  logic                  DecValidQ101H,
  input  logic [REG_ADDR_W-1:0] DecRs1Q101H,
  input  logic [REG_ADDR_W-1:0] DecRs2Q101H,
  input  logic                  DecRs1UsedQ101H,
  input  logic                  DecRs2UsedQ101H,
  input  logic [REG_ADDR_W-1:0] DecRdQ101H,
  input  logic                  DecRegWrEnQ101H,
  input  logic                  DecIsLoadQ101H,
  input  logic                  DecIsMcQ101H,
  input  logic                  FlushQ102H,
  output logic [NUM_STAGES:0]   Ready,
  output logic [NUM_STAGES-1:0] Valid,
  output logic                  KillQ101H,
  output logic                  LoadHazardQ101H,
  output logic                  McBusy,
  output logic                  RetireValid,
  output logic                  RegWrEnWb
);
  localparam int LH = LOAD_DATA_STAGE - 1;
  localparam int CW = 7;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] mc_cnt_q, mc_cnt_d;
  logic [1:0] kill_cnt_q, kill_cnt_d;
  logic [NUM_STAGES:2] v_q, v_d, wr_q, wr_d;
  logic [LH:2] ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [2:LH];
  logic [REG_ADDR_W-1:0] rd_d [2:LH];
  logic mc_q, mc_d;
  logic freeze, v1, hit, mc_entry, mc_hold;
  always_comb begin
    freeze = ~DMemReady;
    KillQ101H = ~Rst & (FlushQ102H | (kill_cnt_q != 2'd0));
    v1 = ~Rst & DecValidQ101H & ~KillQ101H;
    hit = 1'b0;
    for (int k = 2; k <= LH; k++)
      hit = hit | (v_q[k] & ld_q[k] &
            ((DecRs1UsedQ101H & (DecRs1Q101H != '0) & (DecRs1Q101H == rd_q[k])) |
             (DecRs2UsedQ101H & (DecRs2Q101H != '0) & (DecRs2Q101H == rd_q[k]))));
    LoadHazardQ101H = v1 & hit;
    McBusy = state_q == BUSY;
    mc_entry = ~McBusy & v_q[2] & mc_q & (MC_LAT > 1);
    mc_hold = McBusy ? (mc_cnt_q != '0) : mc_entry;
    Ready = {(NUM_STAGES + 1){~freeze}};
    Ready[2] = ~freeze & ~mc_hold;
    Ready[1] = Ready[2] & ~LoadHazardQ101H;
    Ready[0] = Ready[1];
    Valid = {v_q, v1};
    RetireValid = v_q[NUM_STAGES] & Ready[NUM_STAGES];
    RegWrEnWb = RetireValid & wr_q[NUM_STAGES];
    v_d[2] = Ready[1] ? v1 : Ready[2] ? 1'b0 : v_q[2];
    wr_d[2] = Ready[1] ? DecRegWrEnQ101H : wr_q[2];
    ld_d[2] = Ready[1] ? DecIsLoadQ101H : ld_q[2];
    rd_d[2] = Ready[1] ? DecRdQ101H : rd_q[2];
    mc_d = Ready[1] ? DecIsMcQ101H : mc_q;
    for (int k = 3; k <= NUM_STAGES; k++) begin
      v_d[k] = Ready[k-1] ? v_q[k-1] : Ready[k] ? 1'b0 : v_q[k];
      wr_d[k] = Ready[k-1] ? wr_q[k-1] : wr_q[k];
    end
    for (int k = 3; k <= LH; k++) begin
      ld_d[k] = Ready[k-1] ? ld_q[k-1] : ld_q[k];
      rd_d[k] = Ready[k-1] ? rd_q[k-1] : rd_q[k];
    end
    state_d = freeze ? state_q : McBusy ? ((mc_cnt_q == '0) ? IDLE : BUSY) : (mc_entry ? BUSY : IDLE);
    mc_cnt_d = freeze ? mc_cnt_q :
               McBusy ? ((mc_cnt_q == '0) ? mc_cnt_q : mc_cnt_q - CW'(1)) :
               mc_entry ? CW'(MC_LAT - 2) : mc_cnt_q;
    kill_cnt_d = freeze ? kill_cnt_q : FlushQ102H ? 2'(FETCH_LAT - 1) :
                 (kill_cnt_q != 2'd0) ? kill_cnt_q - 2'd1 : kill_cnt_q;
  end
  always_ff @(posedge Clock or posedge Rst)
    if (Rst) begin
      state_q <= IDLE;
      mc_cnt_q <= '0;
      kill_cnt_q <= '0;
      v_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      mc_q <= 1'b0;
      for (int k = 2; k <= LH; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      mc_cnt_q <= mc_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      v_q <= v_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
      mc_q <= mc_d;
      rd_q <= rd_d;
    end
  a_no_flush_on_mc: assert property (@(posedge Clock) disable iff (Rst) !(FlushQ102H && v_q[2] && mc_q));
endmodule

// File: tb/tb_core_rrv_pipe_hazard_ctrl.sv
// tb_core_rrv_pipe_hazard_ctrl: directed self-checking bench for the pipeline hazard controller
module tb_core_rrv_pipe_hazard_ctrl;
  localparam int N = 5;
  logic Clock = 1'b0, Rst, DMemReady, DecValidQ101H;
  logic [4:0] DecRs1Q101H, DecRs2Q101H, DecRdQ101H;
  logic DecRs1UsedQ101H, DecRs2UsedQ101H, DecRegWrEnQ101H, DecIsLoadQ101H, DecIsMcQ101H, FlushQ102H;
  logic [N:0] Ready;
  logic [N-1:0] Valid;
  logic KillQ101H, LoadHazardQ101H, McBusy, RetireValid, RegWrEnWb;
  int errs = 0, checks = 0, ret_cnt = 0;
  core_rrv_pipe_hazard_ctrl dut (
    .Clock(Clock), .Rst(Rst), .DMemReady(DMemReady), .DecValidQ101H(DecValidQ101H),
    .DecRs1Q101H(DecRs1Q101H), .DecRs2Q101H(DecRs2Q101H),
    .DecRs1UsedQ101H(DecRs1UsedQ101H), .DecRs2UsedQ101H(DecRs2UsedQ101H),
    .DecRdQ101H(DecRdQ101H), .DecRegWrEnQ101H(DecRegWrEnQ101H), .DecIsLoadQ101H(DecIsLoadQ101H),
    .DecIsMcQ101H(DecIsMcQ101H), .FlushQ102H(FlushQ102H), .Ready(Ready), .Valid(Valid),
    .KillQ101H(KillQ101H), .LoadHazardQ101H(LoadHazardQ101H), .McBusy(McBusy),
    .RetireValid(RetireValid), .RegWrEnWb(RegWrEnWb)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic we, input logic ld, input logic mc);
    DecValidQ101H = v;
    DecRs1Q101H = r1;
    DecRs2Q101H = r2;
    DecRs1UsedQ101H = u1;
    DecRs2UsedQ101H = u2;
    DecRdQ101H = rd;
    DecRegWrEnQ101H = we;
    DecIsLoadQ101H = ld;
    DecIsMcQ101H = mc;
  endtask
  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic nxt();
    ret_cnt += int'(RetireValid);
    @(negedge Clock);
  endtask
  initial begin
    int pc, busy_n, r0_low, rel;
    Rst = 1'b1;
    DMemReady = 1'b1;
    FlushQ102H = 1'b0;
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0);
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_valid", Valid, 0);
    chk("rst_mcbusy", McBusy, 0);
    chk("rst_retire", RetireValid, 0);
    chk("rst_kill", KillQ101H, 0);
    nop();
    Rst = 1'b0;
    @(negedge Clock);
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    #1;
    chk("lw_r1", Ready[1], 1);
    chk("lw_hz", LoadHazardQ101H, 0);
    nxt();
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0);
    #1;
    chk("lu_hz_c1", LoadHazardQ101H, 1);
    chk("lu_r1_c1", Ready[1], 0);
    chk("lu_r0_c1", Ready[0], 0);
    chk("lu_v2_c1", Valid[1], 1);
    nxt();
    #1;
    chk("lu_hz_c2", LoadHazardQ101H, 1);
    chk("lu_r1_c2", Ready[1], 0);
    chk("lu_v2_c2", Valid[1], 0);
    chk("lu_v3_c2", Valid[2], 1);
    nxt();
    #1;
    chk("lu_hz_c3", LoadHazardQ101H, 0);
    chk("lu_r1_c3", Ready[1], 1);
    chk("lu_v2_c3", Valid[1], 0);
    nxt();
    nop();
    #1;
    chk("lu_add_s2", Valid[1], 1);
    chk("lu_lw_s5", Valid[4], 1);
    chk("lu_retire", RetireValid, 1);
    chk("lu_wb", RegWrEnWb, 1);
    nxt();
    drv(1, 1, 0, 1, 0, 0, 1, 1, 0);
    #1;
    nxt();
    drv(1, 0, 0, 1, 1, 1, 1, 0, 0);
    #1;
    chk("x0_hz", LoadHazardQ101H, 0);
    chk("x0_r1", Ready[1], 1);
    nxt();
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);
    #1;
    nxt();
    drv(1, 5, 5, 0, 0, 5, 1, 0, 0);
    #1;
    chk("lui_hz", LoadHazardQ101H, 0);
    chk("lui_r1", Ready[1], 1);
    nxt();
    drv(1, 5, 0, 1, 1, 7, 1, 0, 0);
    #1;
    chk("s3_hz", LoadHazardQ101H, 1);
    nxt();
    #1;
    chk("s4_hz", LoadHazardQ101H, 0);
    chk("s4_r1", Ready[1], 1);
    nxt();
    nop();
    #1;
    nxt();
    drv(1, 1, 0, 1, 0, 9, 1, 1, 0);
    #1;
    nxt();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    nxt();
    drv(1, 9, 9, 1, 1, 10, 1, 0, 0);
    FlushQ102H = 1'b1;
    #1;
    chk("fl_kill_c0", KillQ101H, 1);
    chk("fl_hz", LoadHazardQ101H, 0);
    chk("fl_r1", Ready[1], 1);
    chk("fl_r0", Ready[0], 1);
    chk("fl_v1_c0", Valid[0], 0);
    nxt();
    FlushQ102H = 1'b0;
    drv(1, 1, 2, 1, 1, 11, 1, 0, 0);
    #1;
    chk("fl_kill_c1", KillQ101H, 1);
    chk("fl_bub1", Valid[1], 0);
    nxt();
    drv(1, 1, 2, 1, 1, 12, 1, 0, 0);
    #1;
    chk("fl_kill_c2", KillQ101H, 0);
    chk("fl_v1_c2", Valid[0], 1);
    chk("fl_bub2", Valid[1], 0);
    nxt();
    nop();
    #1;
    chk("fl_issue", Valid[1], 1);
    nxt();
    drv(1, 1, 2, 1, 1, 13, 1, 0, 1);
    #1;
    nxt();
    drv(1, 3, 4, 1, 1, 14, 1, 0, 0);
    #1;
    chk("mc_a_busy", McBusy, 0);
    chk("mc_a_r2", Ready[2], 0);
    chk("mc_a_r0", Ready[0], 0);
    chk("mc_a_v2", Valid[1], 1);
    nxt();
    #1;
    chk("mc_b_busy", McBusy, 1);
    chk("mc_b_r0", Ready[0], 0);
    chk("mc_b_v3", Valid[2], 0);
    nxt();
    #1;
    chk("mc_c_busy", McBusy, 1);
    chk("mc_c_r2", Ready[2], 0);
    chk("mc_c_v3", Valid[2], 0);
    nxt();
    #1;
    chk("mc_d_busy", McBusy, 1);
    chk("mc_d_r2", Ready[2], 1);
    chk("mc_d_r0", Ready[0], 1);
    chk("mc_d_v3", Valid[2], 0);
    nxt();
    nop();
    #1;
    chk("mc_e_busy", McBusy, 0);
    chk("mc_e_v2", Valid[1], 1);
    chk("mc_e_v3", Valid[2], 1);
    repeat (6) nxt();
    ret_cnt = 0;
    pc = 0;
    busy_n = 0;
    r0_low = 0;
    rel = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      DMemReady = !(cyc >= 4 && cyc <= 6);
      case (pc)
        0: drv(1, 1, 2, 1, 1, 20, 1, 0, 0);
        1: drv(1, 1, 2, 1, 1, 21, 1, 0, 1);
        2: drv(1, 3, 4, 1, 1, 22, 1, 0, 0);
        3: drv(1, 5, 6, 1, 1, 23, 0, 0, 0);
        default: nop();
      endcase
      #1;
      busy_n += int'(McBusy);
      r0_low += int'(!Ready[0]);
      if (McBusy && Ready[2] && rel < 0) rel = cyc;
      if (Ready[1] && pc < 4) pc++;
      nxt();
    end
    DMemReady = 1'b1;
    chk("fz_busy_cycles", busy_n, 6);
    chk("fz_r0_low", r0_low, 6);
    chk("fz_release_cyc", rel, 8);
    chk("fz_issued", pc, 4);
    chk("fz_retired", ret_cnt, 4);
    drv(1, 1, 2, 1, 1, 25, 1, 0, 1);
    #1;
    nxt();
    nop();
    #1;
    nxt();
    #1;
    chk("pre_rst_busy", McBusy, 1);
    #1;
    Rst = 1'b1;
    #1;
    chk("rst_busy_valid", Valid, 0);
    chk("rst_busy_mc", McBusy, 0);
    @(negedge Clock);
    #1;
    Rst = 1'b0;
    @(negedge Clock);
    FlushQ102H = 1'b1;
    #1;
    nxt();
    FlushQ102H = 1'b0;
    #1;
    chk("pre_rst_kill", KillQ101H, 1);
    #1;
    Rst = 1'b1;
    #1;
    chk("rst_kill_async", KillQ101H, 0);
    chk("rst_kill_valid", Valid, 0);
    @(negedge Clock);
    #1;
    Rst = 1'b0;
    drv(1, 1, 2, 1, 1, 24, 1, 0, 0);
    chk("post_rst_kill", KillQ101H, 0);
    nxt();
    nop();
    for (int i = 1; i <= N - 1; i++) begin
      #1;
      chk($sformatf("post_rst_ret_%0d", i), RetireValid, i == N - 1);
      if (i == N - 1) chk("post_rst_wb", RegWrEnWb, 1);
      nxt();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
